mem_port_arbiter: RTL and testbench

//  Shares the single off-chip memory port between the I-cache and D-cache miss engines.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_arb_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter: FSM states, owner codes
// and the default line geometry.
package mem_port_arbiter_pkg;

    localparam int LINE_WORDS_DEF = 4;
    localparam int OFF_W_DEF      = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Grant selection between the I-cache and D-cache miss engines.
// ARB_ROUND_ROBIN_EN: on a tie, grant the cache that did not own the previous burst.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output owner_t grant
);

    always_comb begin
        grant = d_req ? OWN_D : OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant = (last_owner == OWN_D) ? OWN_I : OWN_D;
        end
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority never looks at history; the tie-break input is kept for a uniform interface.
    logic unused_pick_inputs;
    assign unused_pick_inputs = ^{i_req, last_owner};
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the off-chip memory port between the I-cache and D-cache: each grant is a
// LINE_WORDS-word burst (refill or writeback). Tie-break policy set by ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int OFF_W      = OFF_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [WORD_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic [OFF_W-1:0]  i_word,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic [OFF_W-1:0]  d_word,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t                state;
    arb_state_t                state_next;
    owner_t                    owner;
    owner_t                    last_owner;
    owner_t                    grant;
    logic [OFF_W-1:0]          word_cnt;
    logic [WORD_W-OFF_W-1:0]   line_addr;
    logic                      we_lat;
    logic                      burst;
    logic                      own_i;
    logic                      own_d;
    logic                      xfer;
    logic                      last_word;

    arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (last_owner),
        .grant      (grant)
    );

    assign burst     = (state == ARB_BURST);
    assign own_i     = burst && (owner == OWN_I);
    assign own_d     = burst && (owner == OWN_D);
    assign xfer      = burst && mem_ready;
    assign last_word = (word_cnt == OFF_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:  if (i_req || d_req)         state_next = ARB_BURST;
            ARB_BURST: if (mem_ready && last_word) state_next = ARB_IDLE;
            default:                               state_next = ARB_IDLE;
        endcase
    end

    // Request attributes are latched at grant so mid-burst changes on the cache side are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner      <= OWN_D;
            last_owner <= OWN_I;
            word_cnt   <= '0;
            line_addr  <= '0;
            we_lat     <= 1'b0;
        end else if (state == ARB_IDLE) begin
            if (i_req || d_req) begin
                owner     <= grant;
                line_addr <= (grant == OWN_D) ? d_addr[WORD_W-1:OFF_W] : i_addr[WORD_W-1:OFF_W];
                we_lat    <= (grant == OWN_D) ? d_we : i_we;
                word_cnt  <= '0;
            end
        end else if (mem_ready) begin
            word_cnt <= word_cnt + 1'b1;
            if (last_word) begin
                last_owner <= owner;
            end
        end
    end

    always_comb begin
        mem_req   = burst;
        mem_we    = burst && we_lat;
        mem_addr  = burst ? {line_addr, word_cnt} : '0;
        mem_wdata = '0;
        if (own_d)      mem_wdata = d_wdata;
        else if (own_i) mem_wdata = i_wdata;

        i_rvalid = own_i && xfer && !we_lat;
        i_rdata  = i_rvalid ? mem_rdata : '0;
        i_word   = own_i ? word_cnt : '0;
        i_done   = own_i && xfer && last_word;

        d_rvalid = own_d && xfer && !we_lat;
        d_rdata  = d_rvalid ? mem_rdata : '0;
        d_word   = own_d ? word_cnt : '0;
        d_done   = own_d && xfer && last_word;
    end

    // Word-offset bits of the request address are replaced by the burst counter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

`ifndef SYNTHESIS
    req_held_during_burst: assert property (
        @(posedge clk) disable iff (!reset_n)
        (state == ARB_BURST) |-> ((owner == OWN_D) ? d_req : i_req)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenario table, hand-written
// corner sequences and randomized bursts against a transaction-level model.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        i_req, i_we, d_req, d_we;
    logic [15:0] i_addr, d_addr, i_wdata, d_wdata, i_rdata, d_rdata;
    logic        i_rvalid, i_done, d_rvalid, d_done;
    logic [1:0]  i_word, d_word;
    logic        mem_req, mem_we, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] i_wbase, d_wbase;

    int compared   = 0;
    int mismatched = 0;
    bit last_d     = 1'b0;

    assign i_wdata = i_wbase + {14'b0, i_word};
    assign d_wdata = d_wbase + {14'b0, d_word};

    mem_port_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_we      (i_we),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_word    (i_word),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_word    (d_word),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        bit          ri, rd, iwe, dwe;
        logic [15:0] ia, da;
        int          gap;
        bit          first_d_fixed, first_d_rr;
    } vec_t;

    // Winner of a grant decision straight from the arbitration rule.
    function automatic bit pick_d(bit ri, bit rd, bit prev_d);
        if (ri && rd) return RR ? !prev_d : 1'b1;
        return rd;
    endfunction

    function automatic logic [15:0] mem_word(logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input bit active, input bit own_d, input bit we,
                               input logic [15:0] addr, input logic [1:0] k,
                               input bit rdy, input logic [15:0] rdat);
        logic [19:0] exp_side;
        logic [15:0] exp_wdata;
        bit          rv;
        rv        = active && rdy && !we;
        exp_side  = {rv, active && rdy && (k == 2'd3), k, rv ? rdat : 16'h0};
        exp_wdata = active ? ((own_d ? d_wbase : i_wbase) + {14'b0, k}) : 16'h0;
        chk("mem_ctl", {mem_req, mem_we}, {active, active && we});
        chk("mem_addr", mem_addr, active ? {addr[15:2], k} : 16'h0);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("i_side", {i_rvalid, i_done, i_word, i_rdata}, (active && !own_d) ? exp_side : 20'h0);
        chk("d_side", {d_rvalid, d_done, d_word, d_rdata}, (active && own_d) ? exp_side : 20'h0);
    endtask

    // Runs one expected burst; entered and left at posedge+1.
    task automatic applyStimulus(input bit own_d, input bit we, input logic [15:0] addr,
                                 input int gap, input bit drop, input int exp_wait,
                                 input bit chg_addr);
        int          waited;
        int          stall;
        logic [1:0]  k2;
        logic [15:0] rdat;
        waited    = 0;
        mem_ready = 1'b0;
        while (!mem_req && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("grant", mem_req, 1);
        if (exp_wait >= 0) chk("grant_latency", waited, exp_wait);
        if (!mem_req) return;
        for (int k = 0; k < 4; k++) begin
            k2    = k[1:0];
            stall = (gap == 0) ? int'($urandom_range(0, 2)) : gap - 1;
            for (int s = 0; s <= stall; s++) begin
                mem_ready = (s == stall);
                rdat      = mem_word({addr[15:2], k2});
                mem_rdata = mem_ready ? rdat : 16'($urandom);
                if (chg_addr && k == 1 && s == 0) begin
                    i_addr = i_addr ^ 16'hFF00;
                    d_addr = d_addr ^ 16'hFF00;
                end
                @(negedge clk);
                checkOutput(1'b1, own_d, we, addr, k2, mem_ready, rdat);
                @(posedge clk); #1;
            end
        end
        mem_ready = 1'b0;
        last_d    = own_d;
        if (drop) begin
            if (own_d) d_req = 1'b0;
            else       i_req = 1'b0;
        end
        @(negedge clk);
        checkOutput(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0);
        @(posedge clk); #1;
    endtask

    vec_t vecs[4];

    initial begin
        bit fd;
        bit ri, rd, own;
        bit iw, dw;
        logic [15:0] ia, da;

        vecs[0] = '{ri:1, rd:0, iwe:0, dwe:0, ia:16'h0123, da:16'h0000, gap:3, first_d_fixed:0, first_d_rr:0};
        vecs[1] = '{ri:0, rd:1, iwe:0, dwe:1, ia:16'h0000, da:16'h0040, gap:1, first_d_fixed:1, first_d_rr:1};
        vecs[2] = '{ri:1, rd:1, iwe:0, dwe:0, ia:16'h0200, da:16'h0310, gap:1, first_d_fixed:1, first_d_rr:0};
        vecs[3] = '{ri:1, rd:1, iwe:1, dwe:1, ia:16'h0404, da:16'h0508, gap:0, first_d_fixed:1, first_d_rr:0};

        reset_n = 1'b0;
        i_req = 0; d_req = 0; i_we = 0; d_we = 0;
        i_addr = 0; d_addr = 0; mem_ready = 0; mem_rdata = 0;
        i_wbase = 16'h1000; d_wbase = 16'hA000;
        repeat (2) @(posedge clk);
        #1;
        checkOutput(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            i_we = vecs[v].iwe; d_we = vecs[v].dwe;
            i_addr = vecs[v].ia; d_addr = vecs[v].da;
            i_req = vecs[v].ri; d_req = vecs[v].rd;
            fd = RR ? vecs[v].first_d_rr : vecs[v].first_d_fixed;
            applyStimulus(fd, fd ? vecs[v].dwe : vecs[v].iwe, fd ? vecs[v].da : vecs[v].ia,
                          vecs[v].gap, 1'b1, 1, 1'b0);
            if (vecs[v].ri && vecs[v].rd)
                applyStimulus(!fd, fd ? vecs[v].iwe : vecs[v].dwe, fd ? vecs[v].ia : vecs[v].da,
                              vecs[v].gap, 1'b1, 0, 1'b0);
        end

        // Both caches hold their requests across four bursts.
        i_we = 0; d_we = 1; i_addr = 16'h0810; d_addr = 16'h0920;
        i_req = 1; d_req = 1;
        for (int b = 0; b < 4; b++) begin
            own = pick_d(1'b1, 1'b1, last_d);
            applyStimulus(own, own ? 1'b1 : 1'b0, own ? 16'h0920 : 16'h0810, 1,
                          b == 3, (b == 0) ? 1 : 0, 1'b0);
        end
        own = !last_d;
        applyStimulus(own, own ? 1'b1 : 1'b0, own ? 16'h0920 : 16'h0810, 1, 1'b1, 0, 1'b0);

        // Reset asserted after the second word of a refill.
        i_we = 0; i_addr = 16'h0700; i_req = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            mem_ready = 1'b1;
            mem_rdata = mem_word({14'h01C0, k[1:0]});
            @(negedge clk);
            checkOutput(1'b1, 1'b0, 1'b0, 16'h0700, k[1:0], 1'b1, mem_rdata);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        checkOutput(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        last_d = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0700, 1, 1'b1, 1, 1'b0);

        // mem_ready pulses while idle, then an address change mid-burst.
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1;
            mem_rdata = 16'($urandom);
            @(negedge clk);
            checkOutput(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        i_we = 0; i_addr = 16'h0BE4; i_req = 1;
        applyStimulus(1'b0, 1'b0, 16'h0BE4, 2, 1'b1, 1, 1'b1);

        // Randomized request mixes against the arbitration rule.
        for (int it = 0; it < 24; it++) begin
            ri = 1'($urandom_range(0, 1));
            rd = ri ? 1'($urandom_range(0, 1)) : 1'b1;
            iw = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            ia = 16'($urandom); da = 16'($urandom);
            i_wbase = 16'($urandom); d_wbase = 16'($urandom);
            i_we = iw; d_we = dw; i_addr = ia; d_addr = da;
            i_req = ri; d_req = rd;
            own = pick_d(ri, rd, last_d);
            applyStimulus(own, own ? dw : iw, own ? da : ia, 0, 1'b1, 1, 1'b0);
            if (ri && rd)
                applyStimulus(!own, own ? iw : dw, own ? ia : da, 0, 1'b1, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
